instruction_fetch: RTL and testbench

Fetch stage directly downstream of the program counter: samples `programCounter`, performs one request/acknowledge read of instruction memory per instruction, and registers the returned word for the decoder. `fetch_stall` holds the program counter (OR-ed into its hold input alongside `HLT`) until the current fetch completes. A pending control-flow change (`flush`) squashes the in-flight word.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_timeout_counter.sv | 30 +++
 rtl/instruction_fetch.sv | 98 +++++++++
 tb/tb_instruction_fetch.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned DEF_ADDR_W = 12;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned NOP_WORD   = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  // Counter width able to hold 0..terminal inclusive.
  function automatic int unsigned cnt_width(input int unsigned terminal);
    return (terminal < 1) ? 1 : $clog2(terminal + 1);
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts WAIT cycles without acknowledge; saturates at TERMINAL and flags it.
module fetch_timeout_counter
  import fetch_pkg::*;
#(
  parameter int unsigned TERMINAL = 15
) (
  input  logic clock,
  input  logic resetCPU,
  input  logic en,
  input  logic clr,
  output logic terminal_c
);

  localparam int unsigned CNT_W = cnt_width(TERMINAL);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or posedge resetCPU) begin
    if (resetCPU) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !terminal_c) begin
      count <= count + CNT_W'(1);
    end
  end

  assign terminal_c = (count == CNT_W'(TERMINAL));

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: one req/ack instruction-memory read per word, registered for decode.
// Optional memory timeout with sticky fault is enabled by defining FETCH_TIMEOUT_EN.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic              clock,
  input  logic              resetCPU,
  input  logic [ADDR_W-1:0] programCounter,
  input  logic              HLT,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  output logic              fetch_stall,
  output logic              fetch_fault
);

  fetch_state_t state;
  logic         flush_pending;

  // The PC may advance only on the edge that completes the current fetch.
  assign fetch_stall = !((state == WAIT) && imem_ack);

`ifdef FETCH_TIMEOUT_EN
  logic timeout_c;

  fetch_timeout_counter #(
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock      (clock),
    .resetCPU   (resetCPU),
    .en         ((state == WAIT) && !imem_ack),
    .clr        ((state != WAIT) || imem_ack),
    .terminal_c (timeout_c)
  );
`else
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clock or posedge resetCPU) begin
    if (resetCPU) begin
      state         <= IDLE;
      imem_req      <= 1'b0;
      imem_addr     <= '0;
      instruction   <= DATA_W'(NOP_WORD);
      instr_valid   <= 1'b0;
      flush_pending <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      fetch_fault   <= 1'b0;
`endif
    end else begin
      instr_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!HLT) begin
            imem_addr <= programCounter;
            imem_req  <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // Request stays up until acknowledged, regardless of HLT or flush.
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= IDLE;
            if (!flush_pending && !flush) begin
              instruction <= imem_rdata;
              instr_valid <= 1'b1;
            end else begin
              instruction   <= DATA_W'(NOP_WORD);
              flush_pending <= 1'b0;
            end
          end else begin
            if (flush) begin
              flush_pending <= 1'b1;
            end
`ifdef FETCH_TIMEOUT_EN
            if (timeout_c) begin
              imem_req    <= 1'b0;
              fetch_fault <= 1'b1;
              state       <= FAULT;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch with a latency-programmable memory model.
module tb_instruction_fetch;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TO_CYC = 15;

  logic              clock = 1'b0;
  logic              resetCPU;
  logic [ADDR_W-1:0] programCounter;
  logic              HLT;
  logic              flush;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic [DATA_W-1:0] instruction;
  logic              instr_valid;
  logic              fetch_stall;
  logic              fetch_fault;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model controls and scoreboard.
  int                ack_delay   = 0;
  bit                ack_enable  = 1'b1;
  bit                squash_next = 1'b0;
  int                mem_cnt     = 0;
  logic [DATA_W-1:0] next_word   = 32'hA5A5_0001;
  logic [DATA_W-1:0] exp_q[$];
  int                valid_count = 0;

  instruction_fetch #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clock          (clock),
    .resetCPU       (resetCPU),
    .programCounter (programCounter),
    .HLT            (HLT),
    .flush          (flush),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instruction    (instruction),
    .instr_valid    (instr_valid),
    .fetch_stall    (fetch_stall),
    .fetch_fault    (fetch_fault)
  );

  always #5 clock = ~clock;

  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
  end

  // Memory: acks after ack_delay request cycles; expected word queued unless squashed.
  always @(posedge clock) begin
    #1;
    if (imem_req && ack_enable) begin
      if (mem_cnt == ack_delay) begin
        imem_ack   = 1'b1;
        imem_rdata = next_word;
        if (!squash_next) exp_q.push_back(next_word);
        squash_next = 1'b0;
        next_word   = next_word + 1;
        mem_cnt     = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        mem_cnt    = mem_cnt + 1;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      mem_cnt    = 0;
    end
  end

  // Scoreboard: every instr_valid pulse must match the oldest expected word.
  always @(negedge clock) begin
    if (instr_valid) begin
      valid_count = valid_count + 1;
      n_checks = n_checks + 1;
      if (exp_q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL sb_unexpected_valid: got %h, expected no word", instruction);
      end else begin
        logic [DATA_W-1:0] e;
        e = exp_q.pop_front();
        if (instruction !== e) begin
          n_fail = n_fail + 1;
          $display("FAIL sb_word: got %h, expected %h", instruction, e);
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic test_reset();
    resetCPU = 1'b1; HLT = 1'b1; flush = 1'b0; programCounter = '0;
    #1;
    n_checks += 5;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b, expected 0", imem_req); end
    if (imem_addr !== '0) begin n_fail++; $display("FAIL rst_addr: got %h, expected 0", imem_addr); end
    if (instruction !== '0) begin n_fail++; $display("FAIL rst_instr: got %h, expected 0", instruction); end
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, expected 0", instr_valid); end
    if (fetch_stall !== 1'b1) begin n_fail++; $display("FAIL rst_stall: got %b, expected 1", fetch_stall); end
    n_checks++;
    if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b, expected 0", fetch_fault); end
    cyc(); cyc();
    resetCPU = 1'b0;
  endtask

  task automatic test_single_fetch();
    ack_delay = 0;
    cyc(); programCounter = 12'd256; HLT = 1'b0;
    cyc();
    n_checks += 4;
    if (imem_req !== 1'b1) begin n_fail++; $display("FAIL single_req: got %b, expected 1", imem_req); end
    if (imem_addr !== 12'd256) begin n_fail++; $display("FAIL single_addr: got %0d, expected 256", imem_addr); end
    if (fetch_stall !== 1'b0) begin n_fail++; $display("FAIL single_stall_ack: got %b, expected 0", fetch_stall); end
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b, expected 0", instr_valid); end
    HLT = 1'b1;
    cyc();
    n_checks += 4;
    if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b, expected 1", instr_valid); end
    if (instruction !== 32'hA5A5_0001) begin n_fail++; $display("FAIL single_word: got %h, expected a5a50001", instruction); end
    if (fetch_stall !== 1'b1) begin n_fail++; $display("FAIL single_stall_after: got %b, expected 1", fetch_stall); end
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL single_req_drop: got %b, expected 0", imem_req); end
    cyc();
    n_checks++;
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width: got %b, expected 0", instr_valid); end
  endtask

  task automatic test_delayed_ack();
    int v0;
    ack_delay = 5;
    v0 = valid_count;
    cyc(); programCounter = 12'd512; HLT = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(); HLT = 1'b1;
      n_checks += 3;
      if (imem_req !== 1'b1 || imem_addr !== 12'd512) begin
        n_fail++; $display("FAIL delay_req_addr[%0d]: got req=%b addr=%0d, expected req=1 addr=512", i, imem_req, imem_addr);
      end
      if (fetch_stall !== 1'b1) begin n_fail++; $display("FAIL delay_stall[%0d]: got %b, expected 1", i, fetch_stall); end
      if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL delay_valid[%0d]: got %b, expected 0", i, instr_valid); end
    end
    cyc();
    n_checks++;
    if (fetch_stall !== 1'b0) begin n_fail++; $display("FAIL delay_stall_ack: got %b, expected 0", fetch_stall); end
    for (int i = 0; i < 4; i++) cyc();
    n_checks += 2;
    if (valid_count - v0 != 1) begin n_fail++; $display("FAIL delay_pulses: got %0d, expected 1", valid_count - v0); end
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL halt_in_wait_no_refetch: got %b, expected 0", imem_req); end
  endtask

  task automatic test_flush();
    ack_delay = 4; squash_next = 1'b1;
    cyc(); programCounter = 12'h300; HLT = 1'b0;
    cyc(); HLT = 1'b1;
    cyc();
    cyc(); flush = 1'b1;
    cyc(); flush = 1'b0;
    cyc();
    n_checks++;
    if (fetch_stall !== 1'b0) begin n_fail++; $display("FAIL flush_ack_cycle_stall: got %b, expected 0", fetch_stall); end
    cyc();
    n_checks += 2;
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b, expected 0", instr_valid); end
    if (instruction !== '0) begin n_fail++; $display("FAIL flush_instr: got %h, expected 0", instruction); end
    ack_delay = 0;
    programCounter = 12'h304; HLT = 1'b0;
    cyc();
    n_checks++;
    if (imem_addr !== 12'h304 || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL flush_refetch_addr: got req=%b addr=%h, expected req=1 addr=304", imem_req, imem_addr);
    end
    HLT = 1'b1;
    cyc();
    n_checks += 2;
    if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL flush_refetch_valid: got %b, expected 1", instr_valid); end
    if (instruction !== 32'hA5A5_0004) begin n_fail++; $display("FAIL flush_refetch_word: got %h, expected a5a50004", instruction); end
  endtask

  task automatic test_flush_in_ack();
    ack_delay = 2; squash_next = 1'b1;
    cyc(); programCounter = 12'h308; HLT = 1'b0;
    cyc(); HLT = 1'b1;
    cyc();
    cyc(); flush = 1'b1;
    n_checks++;
    if (fetch_stall !== 1'b0) begin n_fail++; $display("FAIL ackflush_stall: got %b, expected 0", fetch_stall); end
    cyc(); flush = 1'b0;
    n_checks += 2;
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL ackflush_valid: got %b, expected 0", instr_valid); end
    if (instruction !== '0) begin n_fail++; $display("FAIL ackflush_instr: got %h, expected 0", instruction); end
  endtask

  task automatic test_halt_idle();
    HLT = 1'b1; flush = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_checks += 2;
      if (imem_req !== 1'b0) begin n_fail++; $display("FAIL halt_req[%0d]: got %b, expected 0", i, imem_req); end
      if (fetch_stall !== 1'b1) begin n_fail++; $display("FAIL halt_stall[%0d]: got %b, expected 1", i, fetch_stall); end
    end
    flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    int v0;
    int k;
    ack_delay = 0; k = 0;
    v0 = valid_count;
    cyc(); programCounter = 12'h400; HLT = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (imem_req && !fetch_stall) begin
        n_checks++;
        if (imem_addr !== 12'(32'h400 + 4 * k)) begin
          n_fail++; $display("FAIL b2b_addr[%0d]: got %h, expected %h", k, imem_addr, 12'(32'h400 + 4 * k));
        end
        k++;
        programCounter = 12'(32'h400 + 4 * k);
      end
    end
    HLT = 1'b1;
    cyc(); cyc(); cyc();
    n_checks += 2;
    if (k != 4) begin n_fail++; $display("FAIL b2b_acks: got %0d, expected 4", k); end
    if (valid_count - v0 != 4) begin n_fail++; $display("FAIL b2b_pulses: got %0d, expected 4", valid_count - v0); end
  endtask

  task automatic test_reset_mid_wait();
    ack_enable = 1'b0;
    cyc(); programCounter = 12'h500; HLT = 1'b0;
    cyc(); HLT = 1'b1;
    n_checks++;
    if (imem_req !== 1'b1) begin n_fail++; $display("FAIL midrst_req_before: got %b, expected 1", imem_req); end
    cyc();
    #1 resetCPU = 1'b1;
    #1;
    n_checks += 4;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL midrst_req: got %b, expected 0", imem_req); end
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b, expected 0", instr_valid); end
    if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL midrst_fault: got %b, expected 0", fetch_fault); end
    if (fetch_stall !== 1'b1) begin n_fail++; $display("FAIL midrst_stall: got %b, expected 1", fetch_stall); end
    cyc(); resetCPU = 1'b0; ack_enable = 1'b1;
    cyc();
    n_checks++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL midrst_after: got %b, expected 0", imem_req); end
  endtask

  task automatic test_timeout();
    ack_enable = 1'b0;
    cyc(); programCounter = 12'h600; HLT = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      cyc(); HLT = 1'b1;
      n_checks++;
      if (fetch_fault !== 1'b0 || imem_req !== 1'b1) begin
        n_fail++; $display("FAIL to_early[%0d]: got fault=%b req=%b, expected fault=0 req=1", i, fetch_fault, imem_req);
      end
    end
    cyc();
    n_checks++;
    if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || fetch_stall !== 1'b1) begin
      n_fail++; $display("FAIL to_fault: got fault=%b req=%b stall=%b, expected 1 0 1", fetch_fault, imem_req, fetch_stall);
    end
    HLT = 1'b0; ack_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if (fetch_fault !== 1'b1 || imem_req !== 1'b0) begin
        n_fail++; $display("FAIL to_sticky[%0d]: got fault=%b req=%b, expected 1 0", i, fetch_fault, imem_req);
      end
    end
    HLT = 1'b1;
`else
    for (int i = 0; i < 20; i++) begin
      cyc(); HLT = 1'b1;
      n_checks++;
      if (fetch_fault !== 1'b0 || imem_req !== 1'b1) begin
        n_fail++; $display("FAIL nofault_wait[%0d]: got fault=%b req=%b, expected 0 1", i, fetch_fault, imem_req);
      end
    end
`endif
    #1 resetCPU = 1'b1;
    #1;
    n_checks++;
    if (fetch_fault !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL to_reset_clear: got fault=%b req=%b, expected 0 0", fetch_fault, imem_req);
    end
    cyc(); resetCPU = 1'b0; ack_enable = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_delayed_ack();
    test_flush();
    test_flush_in_ack();
    test_halt_idle();
    test_back_to_back();
    test_reset_mid_wait();
    test_timeout();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover: got %0d undelivered words, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
